// File: rtl/ysyx_22041071_axi_rd_arb.sv
// ysyx_22041071_axi_rd_arb: two-port (IF / MEM) single-beat AXI read arbiter.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Build option: define YSYX_22041071_ARB_RR_EN for round-robin arbitration;
// otherwise MEM has fixed priority over IF.
module ysyx_22041071_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  // instruction-fetch port
  input  logic              i_if_req_valid,
  input  logic [ADDR_W-1:0] i_if_req_addr,
  input  logic [1:0]        i_if_req_size,
  output logic              o_if_req_ready,
  output logic              o_if_rsp_valid,
  output logic [DATA_W-1:0] o_if_rsp_data,
  output logic [1:0]        o_if_rsp_resp,
  // load-unit port
  input  logic              i_mem_req_valid,
  input  logic [ADDR_W-1:0] i_mem_req_addr,
  input  logic [1:0]        i_mem_req_size,
  output logic              o_mem_req_ready,
  output logic              o_mem_rsp_valid,
  output logic [DATA_W-1:0] o_mem_rsp_data,
  output logic [1:0]        o_mem_rsp_resp,
  // AXI read master side
  output logic              o_m_ar_valid,
  input  logic              i_m_ar_ready,
  output logic [3:0]        o_m_id,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [7:0]        o_m_len,
  output logic [1:0]        o_m_size,
  input  logic              i_m_r_valid,
  input  logic [DATA_W-1:0] i_m_r_data,
  input  logic [1:0]        i_m_r_resp
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic                w_any, w_grant_mem, w_if_ready, w_mem_ready, w_accept;
  logic                r_id;      // 0 = IF, 1 = MEM
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;

  assign w_any    = i_if_req_valid | i_mem_req_valid;
  assign w_accept = (r_state == S_IDLE) & w_any & reset_n;

`ifdef YSYX_22041071_ARB_RR_EN
  logic r_ptr; // 1: MEM wins a tie, 0: IF wins a tie

  // Priority goes to whichever port was not granted last.
  always_ff @(posedge clk) begin
    if (!reset_n)      r_ptr <= 1'b1;
    else if (w_accept) r_ptr <= ~w_grant_mem;
  end

  assign w_grant_mem = i_mem_req_valid & (~i_if_req_valid | r_ptr);
`else
  assign w_grant_mem = i_mem_req_valid;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and grant decode; ready is only ever raised in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_if_ready  = 1'b0;
    w_mem_ready = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_nxt = S_ISSUE;
        w_mem_ready = w_grant_mem;
        w_if_ready  = ~w_grant_mem;
      end
      S_ISSUE: if (i_m_ar_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (i_m_r_valid)  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch on grant, response latch on the first data beat in WAIT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_id   <= 1'b0;
      r_addr <= '0;
      r_size <= 2'b00;
      r_data <= '0;
      r_resp <= 2'b00;
    end else begin
      if (w_accept) begin
        r_id   <= w_grant_mem;
        r_addr <= w_grant_mem ? i_mem_req_addr : i_if_req_addr;
        r_size <= w_grant_mem ? i_mem_req_size : i_if_req_size;
      end
      if (r_state == S_WAIT && i_m_r_valid) begin
        r_data <= i_m_r_data;
        r_resp <= i_m_r_resp;
      end
    end
  end

  assign o_if_req_ready  = w_if_ready;
  assign o_mem_req_ready = w_mem_ready;

  // Response data is shown only on the granted port during its pulse.
  assign o_if_rsp_valid  = (r_state == S_RESP) & ~r_id;
  assign o_mem_rsp_valid = (r_state == S_RESP) &  r_id;
  assign o_if_rsp_data   = o_if_rsp_valid  ? r_data : '0;
  assign o_if_rsp_resp   = o_if_rsp_valid  ? r_resp : 2'b00;
  assign o_mem_rsp_data  = o_mem_rsp_valid ? r_data : '0;
  assign o_mem_rsp_resp  = o_mem_rsp_valid ? r_resp : 2'b00;

  assign o_m_ar_valid = (r_state == S_ISSUE);
  assign o_m_id       = {3'b000, r_id};
  assign o_m_addr     = r_addr;
  assign o_m_len      = 8'h00;
  assign o_m_size     = r_size;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// tb_ysyx_22041071_axi_rd_arb: scenario tasks plus a randomized run checked
// against a transaction-level model (grant rule, latency formula, echo of data).
// Define YSYX_22041071_ARB_RR_EN for both bench and RTL to check round-robin.
module tb_ysyx_22041071_axi_rd_arb;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        if_v = 0, mem_v = 0, ar_rdy = 0, r_v = 0;
  logic [63:0] if_a = 0, mem_a = 0, r_d = 0;
  logic [1:0]  if_s = 0, mem_s = 0, r_rs = 0;
  logic        if_rdy, if_rv, mem_rdy, mem_rv, ar_v;
  logic [63:0] if_rd, mem_rd, m_addr;
  logic [1:0]  if_rr, mem_rr, m_size;
  logic [3:0]  m_id;
  logic [7:0]  m_len;
  int          checks = 0, errors = 0;
  logic        pri_mem = 1'b1; // model: which port wins a tie next

  ysyx_22041071_axi_rd_arb dut (
    .clk(clk), .reset_n(reset_n),
    .i_if_req_valid(if_v), .i_if_req_addr(if_a), .i_if_req_size(if_s),
    .o_if_req_ready(if_rdy), .o_if_rsp_valid(if_rv), .o_if_rsp_data(if_rd), .o_if_rsp_resp(if_rr),
    .i_mem_req_valid(mem_v), .i_mem_req_addr(mem_a), .i_mem_req_size(mem_s),
    .o_mem_req_ready(mem_rdy), .o_mem_rsp_valid(mem_rv), .o_mem_rsp_data(mem_rd), .o_mem_rsp_resp(mem_rr),
    .o_m_ar_valid(ar_v), .i_m_ar_ready(ar_rdy), .o_m_id(m_id), .o_m_addr(m_addr), .o_m_len(m_len),
    .o_m_size(m_size), .i_m_r_valid(r_v), .i_m_r_data(r_d), .i_m_r_resp(r_rs));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic int exp_winner();
    return (mem_v && (!if_v || pri_mem)) ? 1 : 0;
  endfunction

  function automatic void note_grant(input int g);
`ifdef YSYX_22041071_ARB_RR_EN
    pri_mem = (g == 0);
`else
    pri_mem = 1'b1;
`endif
  endfunction

  // Plays the AXI master for one transaction and reports what was observed.
  // Call at a negedge in IDLE with the request(s) already driven; returns at
  // the IDLE negedge after the response. bad counts protocol violations.
  task automatic serve(input int ad, input int rd, input logic [63:0] d, input logic [1:0] rs,
                       output int gport, output logic [3:0] oid, output logic [63:0] oaddr,
                       output logic [1:0] osize, output logic [7:0] olen, output int rport,
                       output logic [63:0] odata, output logic [1:0] oresp,
                       output int lat, output int bad);
    int t = 0;
    bad = 0; gport = -1; rport = -1; lat = 0; odata = 0; oresp = 0;
    oid = 0; oaddr = 0; osize = 0; olen = 0;
    #1;
    while (!if_rdy && !mem_rdy && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) begin bad = 1000; return; end
    if (if_rdy && mem_rdy) bad++;
    gport = mem_rdy ? 1 : 0;
    lat = 1;
    @(posedge clk); #1;
    if (gport == 1) mem_v = 0; else if_v = 0;
    for (int k = 0; k <= ad; k++) begin
      @(negedge clk); lat++;
      if (!ar_v || if_rdy || mem_rdy || if_rv || mem_rv) bad++;
      if (k == 0) begin oid = m_id; oaddr = m_addr; osize = m_size; olen = m_len; end
      else if (m_addr !== oaddr || m_size !== osize || m_id !== oid) bad++;
      ar_rdy = (k == ad);
      r_v = (k != ad); r_d = ~d; r_rs = ~rs; // stray beat while stalled
    end
    @(posedge clk); #1; ar_rdy = 0; r_v = 0;
    for (int k = 0; k <= rd; k++) begin
      @(negedge clk); lat++;
      if (ar_v || if_rdy || mem_rdy || if_rv || mem_rv) bad++;
      r_v = (k == rd); r_d = d; r_rs = rs;
    end
    @(posedge clk); #1; r_v = 0;
    @(negedge clk); lat++;
    rport = (if_rv && mem_rv) ? 2 : if_rv ? 0 : mem_rv ? 1 : -1;
    odata = if_rv ? if_rd : mem_rd;
    oresp = if_rv ? if_rr : mem_rr;
    if (if_rdy || mem_rdy || ar_v) bad++;
    if (if_rv && (mem_rd !== 0 || mem_rr !== 0)) bad++;
    if (mem_rv && (if_rd !== 0 || if_rr !== 0)) bad++;
    r_v = 1; r_d = ~d; // stray beat in RESP
    @(negedge clk);
    r_v = 0;
    if (if_rv || mem_rv) bad++;
  endtask

  task automatic test_reset();
    reset_n = 0; if_v = 1; mem_v = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_rdy, mem_rdy} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", {if_rdy, mem_rdy});
    end
    checks++;
    if ({if_rv, if_rd, if_rr, mem_rv, mem_rd, mem_rr, ar_v, m_id, m_addr, m_len, m_size} !== '0) begin
      errors++; $display("FAIL reset_outputs ar_v=%b id=%h addr=%h len=%h size=%b rv=%b%b",
                         ar_v, m_id, m_addr, m_len, m_size, if_rv, mem_rv);
    end
    if_v = 0; mem_v = 0; reset_n = 1; pri_mem = 1'b1;
    @(negedge clk);
    checks++;
    if ({ar_v, if_rdy, mem_rdy, if_rv, mem_rv} !== 5'b0) begin
      errors++; $display("FAIL reset_idle got %b exp 00000", {ar_v, if_rdy, mem_rdy, if_rv, mem_rv});
    end
  endtask

  task automatic test_single_if();
    int gp, rp, lat, bad; logic [3:0] id; logic [63:0] a, d; logic [1:0] s, r; logic [7:0] l;
    if_v = 1; if_a = 64'h8000_0004; if_s = 2'b10;
    serve(0, 0, 64'h1122334455667788, 2'b00, gp, id, a, s, l, rp, d, r, lat, bad);
    note_grant(gp);
    checks++; if (gp !== 0 || id !== 4'd0) begin errors++; $display("FAIL single_grant got %0d/%0d exp 0", gp, id); end
    checks++; if (a !== 64'h8000_0004 || s !== 2'b10 || l !== 8'h00) begin
      errors++; $display("FAIL single_ar got %h/%b/%h exp 80000004/10/00", a, s, l); end
    checks++; if (rp !== 0 || d !== 64'h1122334455667788 || r !== 2'b00) begin
      errors++; $display("FAIL single_rsp got port %0d %h/%b exp 0 1122334455667788/00", rp, d, r); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency got %0d exp 4", lat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_protocol got %0d exp 0", bad); end
  endtask

  // Both ports request together, once after a MEM-only grant so that
  // round-robin hands the tie to IF.
  task automatic test_simultaneous();
    int gp, rp, lat, bad, eg; logic [3:0] id; logic [63:0] a, d; logic [1:0] s, r; logic [7:0] l;
    mem_v = 1; mem_a = 64'h100; mem_s = 2'b11;
    serve(0, 1, 64'h5, 2'b00, gp, id, a, s, l, rp, d, r, lat, bad);
    note_grant(gp);
    checks++; if (gp !== 1 || rp !== 1 || bad !== 0) begin
      errors++; $display("FAIL sim_pre got grant %0d rsp %0d bad %0d exp 1 1 0", gp, rp, bad); end
    if_v = 1; if_a = 64'hA0; if_s = 2'b01; mem_v = 1; mem_a = 64'hB0; mem_s = 2'b00;
    for (int n = 0; n < 2; n++) begin
      eg = exp_winner();
      serve(1, 0, 64'hC0DE0000 + 64'(n), 2'b00, gp, id, a, s, l, rp, d, r, lat, bad);
      note_grant(gp);
      checks++; if (gp !== eg || id !== 4'(eg) || rp !== eg) begin
        errors++; $display("FAIL sim_grant%0d got %0d/%0d/%0d exp %0d", n, gp, id, rp, eg); end
      checks++; if (a !== (eg ? 64'hB0 : 64'hA0) || d !== 64'hC0DE0000 + 64'(n) || bad !== 0) begin
        errors++; $display("FAIL sim_data%0d got %h/%h bad %0d", n, a, d, bad); end
    end
`ifdef YSYX_22041071_ARB_RR_EN
    eg = 0;
`else
    eg = 1;
`endif
    checks++; if (gp === eg) begin errors++; $display("FAIL sim_order last grant %0d exp %0d", gp, 1 - eg); end
  endtask

  task automatic test_ar_stall();
    int gp, rp, lat, bad, rd; logic [3:0] id; logic [63:0] a, d; logic [1:0] s, r; logic [7:0] l;
    rd = $urandom_range(0, 2);
    if_v = 1; if_a = 64'h8000_1230; if_s = 2'b11;
    serve(5, rd, 64'hFEED, 2'b01, gp, id, a, s, l, rp, d, r, lat, bad);
    note_grant(gp);
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_protocol got %0d exp 0", bad); end
    checks++; if (lat !== 9 + rd) begin errors++; $display("FAIL stall_latency got %0d exp %0d", lat, 9 + rd); end
    checks++; if (a !== 64'h8000_1230 || d !== 64'hFEED || r !== 2'b01 || rp !== 0) begin
      errors++; $display("FAIL stall_rsp got %h/%h/%b port %0d", a, d, r, rp); end
  endtask

  task automatic test_err_resp();
    int gp, rp, lat, bad; logic [3:0] id; logic [63:0] a, d; logic [1:0] s, r; logic [7:0] l;
    mem_v = 1; mem_a = 64'h2000; mem_s = 2'b10;
    serve(0, 0, 64'hDEAD, 2'b10, gp, id, a, s, l, rp, d, r, lat, bad);
    note_grant(gp);
    checks++; if (rp !== 1 || r !== 2'b10 || d !== 64'hDEAD) begin
      errors++; $display("FAIL err_rsp got port %0d resp %b data %h exp 1 10 dead", rp, r, d); end
    checks++; if (bad !== 0 || ar_v !== 1'b0) begin errors++; $display("FAIL err_idle bad %0d ar_v %b", bad, ar_v); end
  endtask

  // IF raises and drops a request while MEM's transaction is in flight.
  task automatic test_dangling();
    int gp, rp, lat, bad, extra; logic [3:0] id; logic [63:0] a, d; logic [1:0] s, r; logic [7:0] l;
    extra = 0;
    mem_v = 1; mem_a = 64'h3000; mem_s = 2'b01;
    fork
      serve(4, 0, 64'h77, 2'b00, gp, id, a, s, l, rp, d, r, lat, bad);
      begin repeat (2) @(negedge clk); if_v = 1; if_a = 64'h4000; @(negedge clk); if_v = 0; end
    join
    note_grant(gp);
    repeat (8) begin @(negedge clk); if (if_rdy || mem_rdy || if_rv || mem_rv || ar_v) extra++; end
    checks++; if (bad !== 0 || rp !== 1) begin errors++; $display("FAIL dangle_txn bad %0d port %0d", bad, rp); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL dangle_side_effect got %0d exp 0", extra); end
  endtask

  task automatic test_reset_wait();
    int gp, rp, lat, bad, t, extra; logic [3:0] id; logic [63:0] a, d; logic [1:0] s, r; logic [7:0] l;
    t = 0; extra = 0;
    if_v = 1; if_a = 64'h5000; if_s = 2'b10;
    #1;
    while (!if_rdy && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1; if_v = 0;
    @(negedge clk); ar_rdy = 1;          // ISSUE
    @(posedge clk); #1; ar_rdy = 0;
    @(negedge clk); reset_n = 0;         // WAIT
    @(negedge clk);
    checks++;
    if ({if_rdy, if_rv, if_rd, if_rr, mem_rdy, mem_rv, mem_rd, mem_rr, ar_v, m_id, m_addr, m_len, m_size} !== '0) begin
      errors++; $display("FAIL rstwait_outputs ar_v=%b addr=%h rv=%b%b", ar_v, m_addr, if_rv, mem_rv);
    end
    reset_n = 1; pri_mem = 1'b1;
    r_v = 1; r_d = 64'h99;
    @(negedge clk); r_v = 0;
    repeat (5) begin if (if_rv || mem_rv || ar_v) extra++; @(negedge clk); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rstwait_abort got %0d exp 0", extra); end
    if_v = 1; if_a = 64'h6000; if_s = 2'b00;
    serve(0, 0, 64'hABCD, 2'b00, gp, id, a, s, l, rp, d, r, lat, bad);
    note_grant(gp);
    checks++; if (rp !== 0 || d !== 64'hABCD || a !== 64'h6000 || bad !== 0 || lat !== 4) begin
      errors++; $display("FAIL rstwait_fresh port %0d data %h addr %h bad %0d lat %0d", rp, d, a, bad, lat); end
  endtask

  task automatic test_random();
    int gp, rp, lat, bad, ad, rd, eg, pick; logic [3:0] id; logic [63:0] a, d, od, ea;
    logic [1:0] s, r, rs, es; logic [7:0] l;
    for (int n = 0; n < 30; n++) begin
      pick = $urandom_range(0, 2);
      if (!if_v && !mem_v) begin
        if (pick != 1) begin if_v = 1; if_a = {$urandom, $urandom}; if_s = 2'($urandom_range(0, 3)); end
        if (pick != 0) begin mem_v = 1; mem_a = {$urandom, $urandom}; mem_s = 2'($urandom_range(0, 3)); end
      end else if (pick == 0) begin
        if (!if_v) begin if_v = 1; if_a = {$urandom, $urandom}; if_s = 2'($urandom_range(0, 3)); end
        else begin mem_v = 1; mem_a = {$urandom, $urandom}; mem_s = 2'($urandom_range(0, 3)); end
      end
      eg = exp_winner();
      ea = eg ? mem_a : if_a; es = eg ? mem_s : if_s;
      ad = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      d = {$urandom, $urandom}; rs = 2'($urandom_range(0, 3));
      serve(ad, rd, d, rs, gp, id, a, s, l, rp, od, r, lat, bad);
      note_grant(gp);
      checks++;
      if (gp !== eg || id !== 4'(eg) || a !== ea || s !== es || l !== 8'h00) begin
        errors++; $display("FAIL rand_ar%0d grant %0d id %0d addr %h size %b exp %0d %h %b", n, gp, id, a, s, eg, ea, es);
      end
      checks++;
      if (rp !== eg || od !== d || r !== rs || lat !== 4 + ad + rd || bad !== 0) begin
        errors++; $display("FAIL rand_rsp%0d port %0d data %h resp %b lat %0d bad %0d exp %0d %h %b %0d",
                           n, rp, od, r, lat, bad, eg, d, rs, 4 + ad + rd);
      end
    end
    while (if_v || mem_v) begin
      eg = exp_winner();
      serve(0, 0, 64'h1, 2'b00, gp, id, a, s, l, rp, od, r, lat, bad);
      note_grant(gp);
      checks++; if (rp !== eg || bad !== 0) begin errors++; $display("FAIL rand_drain port %0d exp %0d bad %0d", rp, eg, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_single_if();
    test_simultaneous();
    test_ar_stall();
    test_err_resp();
    test_dangling();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
YSYX_22041071_AXI_RD_ARB -- requirements
Module: ysyx_22041071_axi_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width of all request and master ports.
REQ-002 SHALL have parameter DATA_W, default 64, data width of all response and master ports.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 if_req_valid  in  1  instruction-fetch read request; held until if_req_ready.
REQ-006 if_req_addr  in  ADDR_W  fetch byte address.
REQ-007 if_req_size  in  2  00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = 8 B.
REQ-008 if_req_ready  out  1  one-cycle pulse: request accepted.
REQ-009 if_rsp_valid  out  1  one-cycle pulse: fetch data valid.
REQ-010 if_rsp_data / if_rsp_resp  out  DATA_W / 2  fetch read data and AXI response.
REQ-011 mem_req_valid, mem_req_addr, mem_req_size, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_resp: same widths and meaning as the if_* ports, for the load unit.
REQ-012 m_ar_valid  out  1  request to the AXI read master.
REQ-013 m_ar_ready  in  1  the AXI read master accepts the request.
REQ-014 m_id  out  4  transaction ID: 0 = IF, 1 = MEM.
REQ-015 m_addr  out  ADDR_W  latched address, unmodified (the master aligns it).
REQ-016 m_len  out  8  constant 0 (single beat).
REQ-017 m_size  out  2  latched size code.
REQ-018 m_r_valid  in  1  read data available from the master.
REQ-019 m_r_data / m_r_resp  in  DATA_W / 2  data and response from the master.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE: on any req_valid, the arbiter SHALL grant one port, pulse that port's req_ready for one cycle, latch addr, size and ID, and go to ISSUE.
REQ-022 ISSUE: m_ar_valid SHALL be 1 and m_id/m_addr/m_size SHALL be stable; on m_ar_ready the FSM SHALL go to WAIT.
REQ-023 WAIT: on the first cycle with m_r_valid=1, the arbiter SHALL register m_r_data and m_r_resp and go to RESP.
REQ-024 RESP: the granted port's rsp_valid SHALL be 1 for exactly one cycle with the registered data and resp; the FSM then SHALL return to IDLE.
REQ-025 The non-granted port's rsp_valid and req_ready SHALL remain 0 for the whole transaction.
REQ-026 Minimum request-to-response latency SHALL be 4 cycles when m_ar_ready and m_r_valid arrive on the first cycle each is sampled.
REQ-027 At most one transaction SHALL be outstanding at a time.
REQ-028 New requests SHALL be ignored outside IDLE; req_ready SHALL stay 0 outside IDLE.
REQ-029 m_r_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-030 m_r_resp SHALL be passed through unchanged; a nonzero value (SLVERR/DECERR) SHALL complete the transaction normally.
REQ-031 A non-granted request that is still held valid SHALL be arbitrated again in the next IDLE cycle.
REQ-032 A dangling request SHALL have no side effect: a req_valid that drops before being granted SHALL not produce any response.

Reset
REQ-033 reset_n=0 SHALL force state IDLE on the next edge.
REQ-034 reset_n=0 SHALL drive all outputs to 0: m_ar_valid, m_id, m_addr, m_len, m_size, both req_ready, both rsp_valid, rsp_data and rsp_resp.
REQ-035 reset_n=0 SHALL clear the round-robin pointer so that MEM has priority.
REQ-036 A reset asserted during ISSUE, WAIT or RESP SHALL abort the transaction; no rsp_valid SHALL be issued for it after reset releases.

Configuration
REQ-037 Macro YSYX_22041071_ARB_RR_EN SHALL select the arbitration policy.
REQ-038 With YSYX_22041071_ARB_RR_EN defined: round-robin; a 1-bit pointer SHALL flip to the other port after each grant, and on simultaneous requests the port that was not granted last SHALL win.
REQ-039 Without YSYX_22041071_ARB_RR_EN: fixed priority, MEM over IF on simultaneous requests; the pointer logic SHALL be absent.

Verification
REQ-040 Single IF request: addr 0x8000_0004, size 10, m_ar_ready same cycle, m_r_data 0x1122334455667788 one cycle later -> m_id=0, m_addr=0x8000_0004, m_size=10, m_len=0; if_rsp_valid pulses once with that data; mem_* outputs stay 0.
REQ-041 Simultaneous IF and MEM requests, fixed priority -> MEM granted first (m_id=1); IF granted in the next IDLE; two separate responses, each on the correct port.
REQ-042 Same stimulus with YSYX_22041071_ARB_RR_EN, previous grant MEM -> IF granted first, then MEM.
REQ-043 m_ar_ready held 0 for 5 cycles -> m_ar_valid stays 1 with m_addr stable for 5 cycles; m_r_valid pulsed during ISSUE is ignored.
REQ-044 m_r_resp=2'b10 returned on a MEM read -> mem_rsp_resp=2'b10, mem_rsp_valid pulses once, FSM back to IDLE.
REQ-045 reset_n=0 for one cycle during WAIT -> all outputs 0; a later m_r_valid produces no rsp_valid; a fresh request is then serviced normally.
